// File: rtl/risc16_pkg.sv
// RiSC-16 shared definitions: opcodes, field positions, widths.
package risc16_pkg;

  localparam int XLEN     = 16;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int RA_HI  = 12;
  localparam int RA_LO  = 10;
  localparam int RB_HI  = 9;
  localparam int RB_LO  = 7;
  localparam int RC_HI  = 2;
  localparam int RC_LO  = 0;
  localparam int I7_HI  = 6;
  localparam int I10_HI = 9;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ADDI = 3'd1,
    OP_NAND = 3'd2,
    OP_LUI  = 3'd3,
    OP_SW   = 3'd4,
    OP_LW   = 3'd5,
    OP_BEQ  = 3'd6,
    OP_JALR = 3'd7
  } opcode_e;

  function automatic logic [XLEN-1:0] sext7(
    input logic [I7_HI:0] imm
  );
    return {{(XLEN-I7_HI-1){imm[I7_HI]}}, imm};
  endfunction

endpackage

// File: rtl/risc16_if.sv
// Instruction fetch bus between the core and an external
// instruction memory.
interface risc16_if;
  import risc16_pkg::*;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inst;

  modport master (output pc, input inst);
  modport slave  (input pc, output inst);

endinterface

// File: rtl/risc16_regfile.sv
// RiSC-16 register file: r0 reads as zero, two async reads,
// one synchronous write.
module risc16_regfile
  import risc16_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [XLEN-1:0]   o_rdata_a,
  output logic [XLEN-1:0]   o_rdata_b
);

  logic [XLEN-1:0] memory [0:NUM_REGS-1] =
    '{default: '0};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        memory[i] <= '0;
    end else if (i_we && i_waddr != '0) begin
      memory[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0
                                       : memory[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0
                                       : memory[i_raddr_b];

endmodule

// File: rtl/risc16_core.sv
// Single-cycle RiSC-16 core: decode, ALU, next-PC and data
// memory around the register file.
module risc16_core
  import risc16_pkg::*;
#(
  parameter int p_DATA_MEM_SIZE = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_inst,
  output logic [XLEN-1:0] o_pc
);

  localparam int AW = $clog2(p_DATA_MEM_SIZE);

  logic [XLEN-1:0] r_pc = '0;
  logic [XLEN-1:0] r_dmem [0:p_DATA_MEM_SIZE-1] =
    '{default: '0};

  opcode_e           w_op;
  logic [REG_AW-1:0] w_ra;
  logic [REG_AW-1:0] w_rb;
  logic [REG_AW-1:0] w_rc;
  logic [REG_AW-1:0] w_rsel_b;
  logic [XLEN-1:0]   w_simm;
  logic [XLEN-1:0]   w_lui;
  logic [XLEN-1:0]   w_rd_a;
  logic [XLEN-1:0]   w_rd_b;
  logic [XLEN-1:0]   w_pc_inc;
  logic [XLEN-1:0]   w_pc_nxt;
  logic [XLEN-1:0]   w_wdata;
  logic [AW-1:0]     w_daddr;
  logic              w_we;
  logic              w_st;

  assign w_op   = opcode_e'(i_inst[OP_HI:OP_LO]);
  assign w_ra   = i_inst[RA_HI:RA_LO];
  assign w_rb   = i_inst[RB_HI:RB_LO];
  assign w_rc   = i_inst[RC_HI:RC_LO];
  assign w_simm = sext7(i_inst[I7_HI:0]);
  assign w_lui  = {i_inst[I10_HI:0], 6'b0};

  // Port B carries rA for store data and branch compare.
  assign w_rsel_b = (w_op == OP_SW || w_op == OP_BEQ)
                  ? w_ra : w_rc;

  risc16_regfile regfile (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_we      (w_we),
    .i_waddr   (w_ra),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_rb),
    .i_raddr_b (w_rsel_b),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

  assign w_daddr  = AW'(w_rd_a + w_simm);
  assign w_pc_inc = r_pc + 16'd1;

  always_comb begin
    w_we     = 1'b0;
    w_st     = 1'b0;
    w_wdata  = '0;
    w_pc_nxt = w_pc_inc;
    unique case (w_op)
      OP_ADD: begin
        w_we    = 1'b1;
        w_wdata = w_rd_a + w_rd_b;
      end
      OP_ADDI: begin
        w_we    = 1'b1;
        w_wdata = w_rd_a + w_simm;
      end
      OP_NAND: begin
        w_we    = 1'b1;
        w_wdata = ~(w_rd_a & w_rd_b);
      end
      OP_LUI: begin
        w_we    = 1'b1;
        w_wdata = w_lui;
      end
      OP_SW: w_st = 1'b1;
      OP_LW: begin
        w_we    = 1'b1;
        w_wdata = r_dmem[w_daddr];
      end
      OP_BEQ: begin
        if (w_rd_a == w_rd_b)
          w_pc_nxt = w_pc_inc + w_simm;
      end
      OP_JALR: begin
        w_we     = 1'b1;
        w_wdata  = w_pc_inc;
        w_pc_nxt = w_rd_a;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_pc <= '0;
    else       r_pc <= w_pc_nxt;
  end

  // Data memory survives reset; reset only blocks the write.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_st)
      r_dmem[w_daddr] <= w_rd_b;
  end

  assign o_pc = r_pc;

endmodule

// File: tb/tb_risc16_core.sv
// Directed table plus random ISA-model regression
// for risc16_core.
module tb_risc16_core;

  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] ADDI = 3'd1;
  localparam logic [2:0] NAND = 3'd2;
  localparam logic [2:0] LUI  = 3'd3;
  localparam logic [2:0] SW   = 3'd4;
  localparam logic [2:0] LW   = 3'd5;
  localparam logic [2:0] BEQ  = 3'd6;
  localparam logic [2:0] JALR = 3'd7;
  localparam int NRAND = 4000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  risc16_if bus ();

  risc16_core #(.p_DATA_MEM_SIZE(1024)) core_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_inst (bus.inst),
    .o_pc   (bus.pc)
  );

  always #5 clk = ~clk;

  // Reference ISA state.
  logic [15:0] m_pc;
  logic [15:0] m_reg [0:7];
  logic [15:0] m_mem [0:1023];

  typedef struct {
    logic [15:0] inst;
    int          rd;
    logic [15:0] val;
    logic [15:0] pc;
  } vec_t;

  vec_t vt [28];

  function automatic logic [15:0] rrr(
    logic [2:0] op, int a, int b, int c);
    logic [2:0] fa, fb, fc;
    fa = a[2:0]; fb = b[2:0]; fc = c[2:0];
    return {op, fa, fb, 4'b0, fc};
  endfunction

  function automatic logic [15:0] ri(
    logic [2:0] op, int a, int b, int imm);
    logic [2:0] fa, fb;
    logic [6:0] fi;
    fa = a[2:0]; fb = b[2:0]; fi = imm[6:0];
    return {op, fa, fb, fi};
  endfunction

  function automatic logic [15:0] lui(int a, int imm);
    logic [2:0] fa;
    logic [9:0] fi;
    fa = a[2:0]; fi = imm[9:0];
    return {LUI, fa, fi};
  endfunction

  function automatic logic [15:0] dut_reg(int i);
    return core_dut.regfile.memory[i];
  endfunction

  task automatic chk(string name, logic [15:0] act,
                     logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h",
               name, act, exp);
    end
  endtask

  task automatic model_step(logic [15:0] inst);
    logic [2:0]  op, a, b, c;
    logic [15:0] simm, ra, rb, rc, npc, ea;
    op   = inst[15:13];
    a    = inst[12:10];
    b    = inst[9:7];
    c    = inst[2:0];
    simm = {{9{inst[6]}}, inst[6:0]};
    ra   = m_reg[a];
    rb   = m_reg[b];
    rc   = m_reg[c];
    npc  = m_pc + 16'd1;
    ea   = rb + simm;
    case (op)
      ADD:  if (a != 0) m_reg[a] = rb + rc;
      ADDI: if (a != 0) m_reg[a] = rb + simm;
      NAND: if (a != 0) m_reg[a] = ~(rb & rc);
      LUI:  if (a != 0) m_reg[a] = {inst[9:0], 6'b0};
      SW:   m_mem[ea[9:0]] = ra;
      LW:   if (a != 0) m_reg[a] = m_mem[ea[9:0]];
      BEQ:  if (ra == rb) npc = m_pc + 16'd1 + simm;
      default: begin
        if (a != 0) m_reg[a] = m_pc + 16'd1;
        npc = rb;
      end
    endcase
    m_pc = npc;
  endtask

  // Called at a falling edge; returns at the next one.
  task automatic exec(logic [15:0] inst);
    bus.inst = inst;
    @(posedge clk);
    if (rst) begin
      m_pc = '0;
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
    end else begin
      model_step(inst);
    end
    @(negedge clk);
  endtask

  task automatic chk_model(string tag);
    chk({tag, " pc"}, bus.pc, m_pc);
    for (int r = 1; r < 8; r++)
      chk($sformatf("%s r%0d", tag, r), dut_reg(r), m_reg[r]);
  endtask

  initial begin
    m_pc = '0;
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    for (int i = 0; i < 1024; i++) m_mem[i] = '0;
    bus.inst = '0;

    vt[0]  = '{ri(ADDI,1,0,-1),    1, 16'hFFFF, 16'h0001};
    vt[1]  = '{rrr(ADD,2,1,1),     2, 16'hFFFE, 16'h0002};
    vt[2]  = '{lui(3,10'h3FF),     3, 16'hFFC0, 16'h0003};
    vt[3]  = '{rrr(NAND,4,3,3),    4, 16'h003F, 16'h0004};
    vt[4]  = '{ri(ADDI,1,0,5),     1, 16'h0005, 16'h0005};
    vt[5]  = '{ri(SW,1,0,10),      1, 16'h0005, 16'h0006};
    vt[6]  = '{ri(LW,2,0,10),      2, 16'h0005, 16'h0007};
    vt[7]  = '{ri(BEQ,0,0,-1),     0, 16'h0000, 16'h0007};
    vt[8]  = '{ri(BEQ,1,4,5),      1, 16'h0005, 16'h0008};
    vt[9]  = '{lui(6,10'h3F0),     6, 16'hFC00, 16'h0009};
    vt[10] = '{ri(LW,5,6,10),      5, 16'h0005, 16'h000A};
    vt[11] = '{ri(BEQ,1,2,3),      1, 16'h0005, 16'h000E};
    vt[12] = '{ri(ADDI,6,0,32),    6, 16'h0020, 16'h000F};
    vt[13] = '{ri(JALR,6,6,0),     6, 16'h0010, 16'h0020};
    vt[14] = '{rrr(ADD,0,6,6),     0, 16'h0000, 16'h0021};
    vt[15] = '{lui(7,10'h3FF),     7, 16'hFFC0, 16'h0022};
    vt[16] = '{ri(ADDI,7,7,48),    7, 16'hFFF0, 16'h0023};
    vt[17] = '{ri(JALR,1,7,'h55),  1, 16'h0024, 16'hFFF0};
    vt[18] = '{ri(BEQ,0,0,63),     1, 16'h0024, 16'h0030};
    vt[19] = '{ri(ADDI,3,0,-5),    3, 16'hFFFB, 16'h0031};
    vt[20] = '{ri(SW,3,3,7),       3, 16'hFFFB, 16'h0032};
    vt[21] = '{ri(LW,4,0,2),       4, 16'hFFFB, 16'h0033};
    vt[22] = '{ri(JALR,3,3,0),     3, 16'h0034, 16'hFFFB};
    vt[23] = '{rrr(ADD,5,3,4),     5, 16'h002F, 16'hFFFC};
    vt[24] = '{ri(ADDI,2,0,3),     2, 16'h0003, 16'hFFFD};
    vt[25] = '{rrr(ADD,0,2,2),     0, 16'h0000, 16'hFFFE};
    vt[26] = '{rrr(NAND,7,0,0),    7, 16'hFFFF, 16'hFFFF};
    vt[27] = '{ri(ADDI,6,6,-1),    6, 16'h000F, 16'h0000};

    #1;
    chk("powerup pc", bus.pc, 16'h0000);

    @(negedge clk);
    rst = 1'b1;
    exec(ri(ADDI,1,0,7));
    rst = 1'b0;
    chk("reset pc", bus.pc, 16'h0000);
    chk("reset r1", dut_reg(1), 16'h0000);

    foreach (vt[i]) begin
      exec(vt[i].inst);
      chk($sformatf("vec%0d pc", i), bus.pc, vt[i].pc);
      chk($sformatf("vec%0d r%0d", i, vt[i].rd),
          dut_reg(vt[i].rd), vt[i].val);
    end

    // Mid-program reset; the store must not happen.
    rst = 1'b1;
    exec(ri(SW,4,0,10));
    rst = 1'b0;
    chk("midrst pc", bus.pc, 16'h0000);
    for (int r = 0; r < 8; r++)
      chk($sformatf("midrst r%0d", r), dut_reg(r), 16'h0000);
    exec(ri(LW,1,0,10));
    chk("post-rst lw mem10", dut_reg(1), 16'h0005);
    exec(ri(LW,2,0,2));
    chk("post-rst lw mem2", dut_reg(2), 16'hFFFB);
    chk("post-rst pc", bus.pc, 16'h0002);

    for (int k = 0; k < NRAND; k++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      exec(ins);
      chk_model($sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
